// File: rtl/block_stream_gen.sv
// Command-to-ASCII generator for the block-nesting protocol: BEGIN/END/CLOSE_ALL/SPACE
// commands become space-terminated "begin"/"end" words, one character per transfer.
module block_stream_gen #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd,
  input  logic               cmd_upper,
  output logic [7:0]         out_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic               balanced
);

  localparam logic [1:0] C_BEGIN = 2'b00;
  localparam logic [1:0] C_END   = 2'b01;
  localparam logic [1:0] C_CLOSE = 2'b10;
  localparam logic [1:0] C_SPACE = 2'b11;
  localparam logic [DEPTH_W-1:0] D_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_cmd;
  logic               r_upper;
  logic [2:0]         r_idx;
  logic [7:0]         r_out_char;
  logic               r_out_valid;
  logic [DEPTH_W-1:0] r_depth, w_depth_upd;
  logic               r_error, w_error_upd;
  logic               w_start, w_xfer, w_last, w_reload;

  function automatic logic [2:0] last_idx(input logic [1:0] c);
    case (c)
      C_BEGIN: return 3'd5;
      C_SPACE: return 3'd0;
      default: return 3'd3;
    endcase
  endfunction

  // Space is never case-shifted; letters drop by 8'h20 for uppercase.
  function automatic logic [7:0] rom_char(input logic [1:0] c, input logic [2:0] idx,
                                          input logic up);
    logic [7:0] ch;
    ch = 8'h20;
    case (c)
      C_BEGIN: begin
        case (idx)
          3'd0:    ch = 8'h62;
          3'd1:    ch = 8'h65;
          3'd2:    ch = 8'h67;
          3'd3:    ch = 8'h69;
          3'd4:    ch = 8'h6E;
          default: ch = 8'h20;
        endcase
      end
      C_END, C_CLOSE: begin
        case (idx)
          3'd0:    ch = 8'h65;
          3'd1:    ch = 8'h6E;
          3'd2:    ch = 8'h64;
          default: ch = 8'h20;
        endcase
      end
      default: ch = 8'h20;
    endcase
    if (up && ch != 8'h20) ch = ch - 8'h20;
    return ch;
  endfunction

  // Depth/error effect of the active word, committed with its final character.
  always_comb begin
    w_start     = cmd_valid && (r_state == S_IDLE) && !(cmd == C_CLOSE && r_depth == '0);
    w_xfer      = r_out_valid && out_ready;
    w_last      = w_xfer && (r_idx == last_idx(r_cmd));
    w_depth_upd = r_depth;
    w_error_upd = r_error;
    case (r_cmd)
      C_BEGIN: begin
        if (r_depth == '1) w_error_upd = 1'b1;
        else               w_depth_upd = r_depth + D_ONE;
      end
      C_END, C_CLOSE: begin
        if (r_depth == '0) w_error_upd = 1'b1;
        else               w_depth_upd = r_depth - D_ONE;
      end
      default: ;
    endcase
    w_reload = w_last && (r_cmd == C_CLOSE) && (w_depth_upd != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_EMIT;
      S_EMIT:  if (w_last && !w_reload) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    balanced  = (r_depth == '0) && !r_error;
    out_char  = r_out_char;
    out_valid = r_out_valid;
    depth     = r_depth;
    error     = r_error;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd       <= C_BEGIN;
      r_upper     <= 1'b0;
      r_idx       <= 3'd0;
      r_out_char  <= 8'h00;
      r_out_valid <= 1'b0;
      r_depth     <= '0;
      r_error     <= 1'b0;
    end else if (w_start) begin
      r_cmd       <= cmd;
      r_upper     <= cmd_upper;
      r_idx       <= 3'd0;
      r_out_char  <= rom_char(cmd, 3'd0, cmd_upper);
      r_out_valid <= 1'b1;
    end else if (w_last) begin
      r_depth <= w_depth_upd;
      r_error <= w_error_upd;
      r_idx   <= 3'd0;
      // CLOSE_ALL chains straight into the next END word without a bubble.
      if (w_reload) r_out_char  <= rom_char(C_END, 3'd0, r_upper);
      else          r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_idx      <= r_idx + 3'd1;
      r_out_char <= rom_char(r_cmd, r_idx + 3'd1, r_upper);
    end
  end

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed, table-driven bench for block_stream_gen: one record per command with the
// expected character stream and resulting depth/error, plus stall, reset and saturation cases.
module tb_block_stream_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       cmd_upper;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] depth;
  logic       error;
  logic       balanced;

  int tests = 0;
  int fails = 0;
  logic [7:0] depth_at5, depth_at9;

  always #5 clk = ~clk;

  block_stream_gen #(.DEPTH_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_upper(cmd_upper), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .depth(depth), .error(error), .balanced(balanced)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic        up;
    int          n;
    logic [95:0] chars;
    logic [7:0]  depth;
    logic        err;
    logic        rst;
  } vec_t;

  vec_t tab[16];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_out_char", 96'(out_char), 96'h00);
    chk("rst_depth", 96'(depth), 96'd0);
    chk("rst_error", 96'(error), 96'd0);
    chk("rst_balanced", 96'(balanced), 96'd1);
    chk("rst_cmd_ready", 96'(cmd_ready), 96'd1);
    $display("[TB] reset applied");
  endtask

  // Issue one command, collect the contiguous character run starting the cycle after acceptance.
  task automatic run_vec(input vec_t v, input int id);
    logic [95:0] got;
    int n, busy_bad;
    got = '0;
    n = 0;
    busy_bad = 0;
    @(negedge clk);
    cmd = v.cmd;
    cmd_upper = v.up;
    cmd_valid = 1'b1;
    chk("cmd_ready_pre", 96'(cmd_ready), 96'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 40 && out_valid; c++) begin
      got = {got[87:0], out_char};
      n++;
      if (cmd_ready) busy_bad++;
      if (n == 5) depth_at5 = depth;
      if (n == 9) depth_at9 = depth;
      @(negedge clk);
    end
    chk("char_count", 96'(n), 96'(v.n));
    chk("char_stream", got, v.chars);
    chk("busy_ready_low", 96'(busy_bad), 96'd0);
    chk("post_out_valid", 96'(out_valid), 96'd0);
    chk("post_cmd_ready", 96'(cmd_ready), 96'd1);
    chk("post_depth", 96'(depth), 96'(v.depth));
    chk("post_error", 96'(error), 96'(v.err));
    chk("post_balanced", 96'(balanced), 96'((v.depth == 8'd0) && !v.err));
    $display("[TB] vec %0d cmd=%0d up=%0b chars=%0d stream=%0h depth=%0d err=%0b",
             id, v.cmd, v.up, n, got, depth, error);
  endtask

  initial begin
    logic [95:0] got;
    int n;
    logic stalled;
    vec_t v;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd = 2'b00;
    cmd_upper = 1'b0;
    out_ready = 1'b1;

    tab[0]  = '{2'b00, 1'b0, 6,  96'h626567696E20, 8'd1, 1'b0, 1'b0};
    tab[1]  = '{2'b01, 1'b0, 4,  96'h656E6420,     8'd0, 1'b0, 1'b0};
    tab[2]  = '{2'b00, 1'b1, 6,  96'h424547494E20, 8'd1, 1'b0, 1'b0};
    tab[3]  = '{2'b01, 1'b0, 4,  96'h656E6420,     8'd0, 1'b0, 1'b0};
    tab[4]  = '{2'b11, 1'b0, 1,  96'h20,           8'd0, 1'b0, 1'b0};
    tab[5]  = '{2'b11, 1'b1, 1,  96'h20,           8'd0, 1'b0, 1'b0};
    tab[6]  = '{2'b01, 1'b0, 4,  96'h656E6420,     8'd0, 1'b1, 1'b0};
    tab[7]  = '{2'b00, 1'b1, 6,  96'h424547494E20, 8'd1, 1'b1, 1'b0};
    tab[8]  = '{2'b01, 1'b1, 4,  96'h454E4420,     8'd0, 1'b1, 1'b0};
    tab[9]  = '{2'b00, 1'b0, 6,  96'h626567696E20, 8'd1, 1'b0, 1'b1};
    tab[10] = '{2'b00, 1'b0, 6,  96'h626567696E20, 8'd2, 1'b0, 1'b0};
    tab[11] = '{2'b00, 1'b1, 6,  96'h424547494E20, 8'd3, 1'b0, 1'b0};
    tab[12] = '{2'b10, 1'b0, 12, 96'h656E6420656E6420656E6420, 8'd0, 1'b0, 1'b0};
    tab[13] = '{2'b10, 1'b1, 0,  96'h0,            8'd0, 1'b0, 1'b0};
    tab[14] = '{2'b00, 1'b0, 6,  96'h626567696E20, 8'd1, 1'b0, 1'b0};
    tab[15] = '{2'b10, 1'b1, 4,  96'h454E4420,     8'd0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (tab[i].rst) do_reset();
      run_vec(tab[i], i);
      if (i == 12) begin
        chk("close_depth_after_1st", 96'(depth_at5), 96'd2);
        chk("close_depth_after_2nd", 96'(depth_at9), 96'd1);
      end
    end

    // Backpressure: hold out_ready low for 3 cycles while 'g' (67) is presented.
    do_reset();
    @(negedge clk);
    cmd = 2'b00;
    cmd_upper = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = '0;
    n = 0;
    stalled = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!stalled && out_valid && out_char == 8'h67) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_char_hold", 96'(out_char), 96'h67);
          chk("stall_valid_hold", 96'(out_valid), 96'd1);
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        got = {got[87:0], out_char};
        n++;
      end
      if (!out_valid && n > 0) break;
      @(negedge clk);
    end
    chk("stall_seen", 96'(stalled), 96'd1);
    chk("stall_count", 96'(n), 96'd6);
    chk("stall_stream", got, 96'h626567696E20);
    chk("stall_depth", 96'(depth), 96'd1);
    $display("[TB] stall test transfers=%0d stream=%0h", n, got);

    // Reset pulsed during END after 'e' has transferred.
    @(negedge clk);
    cmd = 2'b01;
    cmd_upper = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_first_char", 96'(out_char), 96'h65);
    @(negedge clk);
    chk("abort_second_char", 96'(out_char), 96'h6E);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", 96'(out_valid), 96'd0);
    chk("abort_depth", 96'(depth), 96'd0);
    chk("abort_error", 96'(error), 96'd0);
    chk("abort_cmd_ready", 96'(cmd_ready), 96'd1);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("abort_no_more_chars", 96'(n), 96'd0);
    $display("[TB] reset-abort test extra_chars=%0d depth=%0d", n, depth);

    // Depth saturation at all-ones.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      v = '{2'b00, 1'b0, 6, 96'h626567696E20, 8'(i + 1), 1'b0, 1'b0};
      run_vec(v, 100 + i);
    end
    v = '{2'b00, 1'b0, 6, 96'h626567696E20, 8'd255, 1'b1, 1'b0};
    run_vec(v, 400);
    v = '{2'b01, 1'b0, 4, 96'h656E6420, 8'd254, 1'b1, 1'b0};
    run_vec(v, 401);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
